// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - debounced four-candidate vote counter with post-vote lockout.
// Optional VOTE_TALLY_TOTAL_EN adds a saturating total_votes output.
module vote_tally #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int LOCKOUT_CYCLES  = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             button1_raw,
  input  logic             button2_raw,
  input  logic             button3_raw,
  input  logic             button4_raw,
  output logic [CNT_W-1:0] candidate1_vote,
  output logic [CNT_W-1:0] candidate2_vote,
  output logic [CNT_W-1:0] candidate3_vote,
  output logic [CNT_W-1:0] candidate4_vote,
  output logic             candidate1_button_press,
  output logic             candidate2_button_press,
  output logic             candidate3_button_press,
  output logic             candidate4_button_press,
  output logic             valid_vote_casted,
  output logic             invalid_vote
`ifdef VOTE_TALLY_TOTAL_EN
  ,
  output logic [CNT_W+1:0] total_votes
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0]    DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0]    LOCK_INIT = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0]    LOCK_ONE  = LW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {READY, LOCKOUT, WAIT_RELEASE} state_t;

  logic [3:0]       raw, sync1, sync2, level, level_q, events;
  logic [DW-1:0]    db_cnt [4];
  logic [CNT_W-1:0] tally [4];
  logic [LW-1:0]    lock_cnt, lock_next;
  logic [3:0]       inc;
  logic             valid_next, invalid_next;
  state_t           state, next_state;

  assign raw    = {button4_raw, button3_raw, button2_raw, button1_raw};
  assign events = level & ~level_q;

  // Synchroniser, debounce and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state   = state;
    lock_next    = lock_cnt;
    inc          = '0;
    valid_next   = 1'b0;
    invalid_next = 1'b0;
    case (state)
      READY: begin
        if (!mode && events != 4'd0) begin
          // A single set bit means exactly one candidate pressed this cycle
          if ((events & (events - 4'd1)) == 4'd0) begin
            inc        = events;
            valid_next = 1'b1;
            lock_next  = LOCK_INIT;
            next_state = LOCKOUT;
          end else begin
            invalid_next = 1'b1;
            next_state   = WAIT_RELEASE;
          end
        end
      end
      LOCKOUT: begin
        lock_next = lock_cnt - 1'b1;
        if (lock_cnt == LOCK_ONE) next_state = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (level == 4'd0) next_state = READY;
      end
      default: next_state = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= READY;
      lock_cnt          <= '0;
      valid_vote_casted <= 1'b0;
      invalid_vote      <= 1'b0;
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      state             <= next_state;
      lock_cnt          <= lock_next;
      valid_vote_casted <= valid_next;
      invalid_vote      <= invalid_next;
      for (int i = 0; i < 4; i++) begin
        if (inc[i] && tally[i] != CNT_MAX) tally[i] <= tally[i] + 1'b1;
      end
    end
  end

`ifdef VOTE_TALLY_TOTAL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      total_votes <= '0;
    end else if (valid_next && total_votes != {(CNT_W+2){1'b1}}) begin
      total_votes <= total_votes + 1'b1;
    end
  end
`endif

  assign candidate1_vote         = tally[0];
  assign candidate2_vote         = tally[1];
  assign candidate3_vote         = tally[2];
  assign candidate4_vote         = tally[3];
  assign candidate1_button_press = level[0];
  assign candidate2_button_press = level[1];
  assign candidate3_button_press = level[2];
  assign candidate4_button_press = level[3];

endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - directed bench for vote_tally with an expected-pulse scoreboard.
module tb_vote_tally;

  localparam int D = 4;
  localparam int L = 5;

  logic clk = 1'b0;
  logic reset, mode, b1, b2, b3, b4;
  logic [7:0] v1, v2, v3, v4;
  logic p1, p2, p3, p4, valid, invalid;
`ifdef VOTE_TALLY_TOTAL_EN
  logic [9:0] total;
`endif
  logic [7:0] tal [4];

  vote_tally #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .button1_raw(b1), .button2_raw(b2), .button3_raw(b3), .button4_raw(b4),
    .candidate1_vote(v1), .candidate2_vote(v2), .candidate3_vote(v3), .candidate4_vote(v4),
    .candidate1_button_press(p1), .candidate2_button_press(p2),
    .candidate3_button_press(p3), .candidate4_button_press(p4),
    .valid_vote_casted(valid), .invalid_vote(invalid)
`ifdef VOTE_TALLY_TOTAL_EN
    , .total_votes(total)
`endif
  );

  assign tal[0] = v1;
  assign tal[1] = v2;
  assign tal[2] = v3;
  assign tal[3] = v4;

  always #5 clk = ~clk;

  typedef struct {bit inval; int cand; int exp;} ev_t;
  ev_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int valid_seen = 0;
  int exp_tally [4] = '{0, 0, 0, 0};
  int exp_total = 0;
  int valid_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_vote(input int c);
    if (exp_tally[c] < 255) exp_tally[c]++;
    if (exp_total < 1023) exp_total++;
    sb.push_back('{1'b0, c, exp_tally[c]});
  endtask

  task automatic push_invalid();
    sb.push_back('{1'b1, 0, 0});
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < 4; i++) exp_tally[i] = 0;
    exp_total = 0;
  endtask

  // Every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && (valid || invalid)) begin
      ev_t e;
      check("pulse_exclusive", 32'(valid & invalid), 32'd0);
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_pulse: observed valid=%0d invalid=%0d expected none", valid, invalid);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_kind_invalid", 32'(invalid), 32'(e.inval));
        if (!e.inval) check($sformatf("tally%0d_at_pulse", e.cand + 1), 32'(tal[e.cand]), 32'(e.exp));
      end
      if (valid) valid_seen++;
    end
  end

  initial begin
    reset = 1'b1; mode = 1'b0; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; b4 = 1'b0;
    tick(3);
    check("rst_votes", {v1, v2, v3, v4}, 32'd0);
    check("rst_press", {p1, p2, p3, p4}, 32'd0);
    check("rst_pulses", {valid, invalid}, 32'd0);

    // Clean press of button2: debounced at edge D+2, vote at edge D+3
    reset = 1'b0; b2 = 1'b1; push_vote(1);
    tick(D + 1); check("t1_press2_early", 32'(p2), 32'd0);
    tick(1);     check("t1_press2_rise", 32'(p2), 32'd1);
                 check("t1_valid_early", 32'(valid), 32'd0);
    tick(1);     check("t1_valid", 32'(valid), 32'd1);
                 check("t1_votes", {v1, v2, v3, v4}, {8'd0, 8'd1, 8'd0, 8'd0});
    tick(13); b2 = 1'b0; tick(20);

    // Bouncing button1: only the final stable transition counts
    b1 = 1'b1; tick(2); b1 = 1'b0; tick(2); b1 = 1'b1; push_vote(0);
    tick(D + 1); check("t2_press1_early", 32'(p1), 32'd0);
    tick(1);     check("t2_press1_rise", 32'(p1), 32'd1);
    tick(1);     check("t2_valid", 32'(valid), 32'd1);
    tick(15); b1 = 1'b0; tick(20);
    check("t2_vote1_once", 32'(v1), 32'd1);

    // Simultaneous presses are rejected
    b3 = 1'b1; b4 = 1'b1; push_invalid();
    tick(D + 3); check("t3_invalid", 32'(invalid), 32'd1);
                 check("t3_no_valid", 32'(valid), 32'd0);
                 check("t3_votes34", {v3, v4}, 32'd0);
    tick(5); b3 = 1'b0; b4 = 1'b0; tick(20);
    b3 = 1'b1; push_vote(2);
    tick(D + 3); check("t3_valid3", 32'(valid), 32'd1);
                 check("t3_vote3", 32'(v3), 32'd1);
    tick(5); b3 = 1'b0; tick(20);

    // Result-display mode: levels follow, nothing counted
    mode = 1'b1; b4 = 1'b1;
    tick(D + 2); check("t5_press4", 32'(p4), 32'd1);
    tick(10);    check("t5_vote4", 32'(v4), 32'd0);
    b4 = 1'b0;
    tick(D + 2); check("t5_press4_fall", 32'(p4), 32'd0);
    tick(10); mode = 1'b0;

    // Press during lockout is ignored
    b2 = 1'b1; push_vote(1);
    tick(2); b1 = 1'b1;
    tick(D + 1); check("t6_valid2", 32'(valid), 32'd1);
                 check("t6_vote2", 32'(v2), 32'd2);
    tick(20);    check("t6_vote1_unchanged", 32'(v1), 32'd1);
    b1 = 1'b0; b2 = 1'b0; tick(20);

    // Reset in the middle of a lockout, button2 held through it
    b2 = 1'b1; push_vote(1);
    tick(D + 3); check("t6_valid_pre_rst", 32'(valid), 32'd1);
    tick(2);
    reset = 1'b1; model_reset();
    tick(1);     check("t6_rst_votes", {v1, v2, v3, v4}, 32'd0);
                 check("t6_rst_press2", 32'(p2), 32'd0);
`ifdef VOTE_TALLY_TOTAL_EN
                 check("t6_rst_total", 32'(total), 32'd0);
`endif
    reset = 1'b0; push_vote(1);
    tick(D + 2); check("t6_held_press2", 32'(p2), 32'd1);
                 check("t6_held_valid_early", 32'(valid), 32'd0);
    tick(1);     check("t6_held_valid", 32'(valid), 32'd1);
                 check("t6_held_vote2", 32'(v2), 32'd1);
    b2 = 1'b0; tick(20);

    // Saturation: 300 presses of button1
    valid_base = valid_seen;
    for (int n = 0; n < 300; n++) begin
      b1 = 1'b1; push_vote(0);
      tick(10); b1 = 1'b0; tick(20);
    end
    check("t4_vote1_sat", 32'(v1), 32'd255);
    check("t4_valid_count", 32'(valid_seen - valid_base), 32'd300);
    check("t4_vote2_kept", 32'(v2), 32'd1);
`ifdef VOTE_TALLY_TOTAL_EN
    check("t4_total", 32'(total), 32'(exp_total));
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
